e_mdu: RTL

- Execute-stage multiply/divide unit holding the architectural HI/LO registers.
- Sits between the D/E and E/M pipeline registers.
- Consumes decoded operation and forwarded Rs/Rt operands from D/E.
- Provides HI/LO read data to the E-stage result mux, which feeds E/M, and a busy indication to the hazard unit.

---
 rtl/e_mdu_if.sv | 22 ++
 rtl/e_mdu.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/e_mdu_if.sv
// Execute-stage MDU bus: decoded op and operands in, HI/LO and stall status out.
// The pipeline side (master) drives the op; the MDU (slave) drives status and registers.
interface e_mdu_if;
   logic [3:0]  MDUOp;
   logic [31:0] A;
   logic [31:0] B;
   logic        flush;
   logic        busy;
   logic        md_stall;
   logic [31:0] HI;
   logic [31:0] LO;

   modport master (
      output MDUOp, A, B, flush,
      input  busy, md_stall, HI, LO
   );

   modport slave (
      input  MDUOp, A, B, flush,
      output busy, md_stall, HI, LO
   );
endinterface

// File: rtl/e_mdu.sv
// Multiply/divide unit owning HI/LO: mthi/mtlo commit in one edge; mult/div commit MULT_CYCLES/DIV_CYCLES edges after accept.
// No backpressure input: new ops are ignored while busy, and md_stall tells the hazard unit to hold them in D.
module e_mdu #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic     clk,
   input  logic     reset,
   e_mdu_if.slave   mdu
);

   localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW   = $clog2(MAXC + 1);

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MTHI  = 4'd5;
   localparam logic [3:0] OP_MTLO  = 4'd6;

   typedef enum logic {ST_IDLE, ST_BUSY} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [31:0]     hi_q, hi_d;
   logic [31:0]     lo_q, lo_d;
   logic [31:0]     res_hi_q, res_hi_d;
   logic [31:0]     res_lo_q, res_lo_d;
   logic            commit_q, commit_d;

   logic [63:0]     prod_s;
   logic [63:0]     prod_u;
   logic            div_signed;
   logic            a_neg, b_neg;
   logic [31:0]     a_mag, b_mag;
   logic [31:0]     uq, ur;
   logic [31:0]     quo, rem;

   assign prod_s = {{32{mdu.A[31]}}, mdu.A} * {{32{mdu.B[31]}}, mdu.B};
   assign prod_u = {32'd0, mdu.A} * {32'd0, mdu.B};

   // Signed divide runs on magnitudes so 0x80000000 / -1 wraps to 0x80000000 without overflow.
   assign div_signed = (mdu.MDUOp == OP_DIV);
   assign a_neg      = div_signed & mdu.A[31];
   assign b_neg      = div_signed & mdu.B[31];
   assign a_mag      = a_neg ? (32'd0 - mdu.A) : mdu.A;
   assign b_mag      = b_neg ? (32'd0 - mdu.B) : mdu.B;

   always_comb begin
      uq = 32'd0;
      ur = 32'd0;
      if (b_mag != 32'd0) begin
         uq = a_mag / b_mag;
         ur = a_mag % b_mag;
      end
   end

   assign quo = (a_neg ^ b_neg) ? (32'd0 - uq) : uq;
   assign rem = a_neg ? (32'd0 - ur) : ur;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      res_hi_d = res_hi_q;
      res_lo_d = res_lo_q;
      commit_d = commit_q;

      case (state_q)
         ST_IDLE: begin
            if (!mdu.flush) begin
               case (mdu.MDUOp)
                  OP_MULT: begin
                     res_hi_d = prod_s[63:32];
                     res_lo_d = prod_s[31:0];
                     commit_d = 1'b1;
                     cnt_d    = CW'(MULT_CYCLES);
                     state_d  = ST_BUSY;
                  end
                  OP_MULTU: begin
                     res_hi_d = prod_u[63:32];
                     res_lo_d = prod_u[31:0];
                     commit_d = 1'b1;
                     cnt_d    = CW'(MULT_CYCLES);
                     state_d  = ST_BUSY;
                  end
                  OP_DIV, OP_DIVU: begin
                     res_hi_d = rem;
                     res_lo_d = quo;
                     // A zero divisor still occupies the unit but must leave HI/LO alone.
                     commit_d = (mdu.B != 32'd0);
                     cnt_d    = CW'(DIV_CYCLES);
                     state_d  = ST_BUSY;
                  end
                  OP_MTHI: hi_d = mdu.A;
                  OP_MTLO: lo_d = mdu.A;
                  default: ;
               endcase
            end
         end
         ST_BUSY: begin
            if (cnt_q <= CW'(1)) begin
               if (commit_q) begin
                  hi_d = res_hi_q;
                  lo_d = res_lo_q;
               end
               cnt_d   = '0;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         hi_q     <= 32'd0;
         lo_q     <= 32'd0;
         res_hi_q <= 32'd0;
         res_lo_q <= 32'd0;
         commit_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         res_hi_q <= res_hi_d;
         res_lo_q <= res_lo_d;
         commit_q <= commit_d;
      end
   end

   assign mdu.busy     = (state_q == ST_BUSY);
   assign mdu.md_stall = mdu.busy |
                         ((mdu.MDUOp >= OP_MULT) && (mdu.MDUOp <= OP_DIVU) && !mdu.flush);
   assign mdu.HI       = hi_q;
   assign mdu.LO       = lo_q;

endmodule
